bram_flex_mc: RTL and testbench

//  Single-clock multi-channel BRAM: NCH requesters share one flex BRAM array

---
 rtl/bram_flex_mc.sv | 174 +++++++++++++++++
 tb/tb_bram_flex_mc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_flex_mc.sv
// rtl/bram_flex_mc.sv - multi-channel shared BRAM with round-robin arbiter and init engine
// NCH requesters share one memory array; every accepted access returns one response on its channel.
module bram_flex_mc #(
  parameter int    DEPTH             = 5130,
  parameter int    BITS_D            = 20,
  parameter int    NCH               = 4,
  parameter int    OUTREG            = 0,
  parameter string READ_FIRST        = "TRUE",
  parameter int    INIT_ON_RESET     = 1,
  parameter int    INITVALUE_COUNT   = 6,
  parameter int    INITVALUE_ARRAY [INITVALUE_COUNT] = '{2, 4, 6, 7, 1, 3},
  parameter int    INITVALUE_DEFAULT = 10,
  parameter int    BITS_A            = (DEPTH > 1) ? $clog2(DEPTH) : 0,
  localparam int   AW                = (BITS_A < 1) ? 1 : BITS_A
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  output logic                  init_busy,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_wen,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*BITS_D-1:0] req_wdata,
  output logic [NCH-1:0]        rsp_valid,
  output logic [NCH*BITS_D-1:0] rsp_rdata
);

  localparam bit RF = (READ_FIRST == "TRUE");
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;
  localparam state_t S_RST = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_init_addr, w_init_addr_nxt;
  logic                w_init_we;
  logic [BITS_D-1:0]   r_mem [DEPTH];

  logic [CW-1:0]       r_ptr, w_win, w_cand;
  logic                w_any, w_hs, w_wen, w_oob;
  logic [AW-1:0]       w_addr, w_idx;
  logic [BITS_D-1:0]   w_wdata;

  logic                r_p1_v, r_p1_wen, r_p1_oob;
  logic [CW-1:0]       r_p1_ch;
  logic [BITS_D-1:0]   r_p1_wd, r_p1_rd, w_p1_d;
  logic                r_p2_v;
  logic [CW-1:0]       r_p2_ch;
  logic [BITS_D-1:0]   r_p2_d;
  logic                w_fv;
  logic [CW-1:0]       w_fch;
  logic [BITS_D-1:0]   w_fd;
  logic [BITS_D-1:0]   r_hold [NCH];

  function automatic logic [BITS_D-1:0] f_init_word(input logic [AW-1:0] a);
    logic [BITS_D-1:0] v;
    v = BITS_D'(INITVALUE_DEFAULT);
    for (int i = 0; i < INITVALUE_COUNT; i++)
      if (int'(a) == i) v = BITS_D'(INITVALUE_ARRAY[i]);
    return v;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    w_init_we       = 1'b0;
    init_busy       = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_INIT: begin
        init_busy = 1'b1;
        w_init_we = 1'b1;
        if (clr) begin
          w_init_addr_nxt = '0;
        end else if (r_init_addr == AW'(DEPTH - 1)) begin
          w_state_nxt     = S_RUN;
          w_init_addr_nxt = '0;
        end else begin
          w_init_addr_nxt = r_init_addr + 1'b1;
        end
      end
      S_RUN: begin
        if (clr) begin
          w_state_nxt     = S_INIT;
          w_init_addr_nxt = '0;
        end
      end
      default: w_state_nxt = S_RST;
    endcase
  end

  // Grants are gated by clr so nothing is accepted on the edge that restarts init.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = CW'((int'(r_ptr) + k) % NCH);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
    w_hs      = (r_state == S_RUN) && !clr && w_any;
    req_ready = w_hs ? (NCH'(1) << w_win) : '0;
    w_addr    = req_addr[w_win*AW +: AW];
    w_wdata   = req_wdata[w_win*BITS_D +: BITS_D];
    w_wen     = req_wen[w_win];
    w_oob     = (int'(w_addr) >= DEPTH);
    w_idx     = w_oob ? '0 : w_addr;
  end

  always_ff @(posedge clk) begin
    if (w_init_we)
      r_mem[r_init_addr] <= f_init_word(r_init_addr);
    else if (w_hs && w_wen && !w_oob)
      r_mem[w_idx] <= w_wdata;
    if (w_hs)
      r_p1_rd <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_RST;
      r_init_addr <= '0;
      r_ptr       <= '0;
      r_p1_v      <= 1'b0;
      r_p1_ch     <= '0;
      r_p1_wen    <= 1'b0;
      r_p1_oob    <= 1'b0;
      r_p1_wd     <= '0;
      r_p2_v      <= 1'b0;
      r_p2_ch     <= '0;
      r_p2_d      <= '0;
      for (int i = 0; i < NCH; i++) r_hold[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
      r_p1_v      <= w_hs;
      if (w_hs) begin
        r_ptr    <= (w_win == CW'(NCH - 1)) ? '0 : w_win + 1'b1;
        r_p1_ch  <= w_win;
        r_p1_wen <= w_wen;
        r_p1_oob <= w_oob;
        r_p1_wd  <= w_wdata;
      end
      r_p2_v  <= r_p1_v;
      r_p2_ch <= r_p1_ch;
      r_p2_d  <= w_p1_d;
      if (w_fv) r_hold[w_fch] <= w_fd;
    end
  end

  always_comb begin
    w_p1_d = r_p1_oob ? '0 : ((r_p1_wen && !RF) ? r_p1_wd : r_p1_rd);
    if (OUTREG != 0) begin
      w_fv  = r_p2_v;
      w_fch = r_p2_ch;
      w_fd  = r_p2_d;
    end else begin
      w_fv  = r_p1_v;
      w_fch = r_p1_ch;
      w_fd  = w_p1_d;
    end
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      rsp_valid[i] = w_fv && (w_fch == CW'(i));
      rsp_rdata[i*BITS_D +: BITS_D] = rsp_valid[i] ? w_fd : r_hold[i];
    end
  end

endmodule

// File: tb/tb_bram_flex_mc.sv
// tb/tb_bram_flex_mc.sv - directed self-checking bench for bram_flex_mc
// Main instance uses defaults; a second small instance covers OUTREG=1 / write-first.
module tb_bram_flex_mc;
  localparam int AW = 13, DW = 20, N = 4, BAW = 4;

  logic clk = 1'b0, rstn = 1'b0, clr = 1'b0;
  logic init_busy;
  logic [N-1:0] req_valid, req_ready, req_wen, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic b_busy;
  logic [N-1:0] b_valid, b_ready, b_wen, b_rsp_valid;
  logic [N*BAW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata, b_rsp_rdata;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  bram_flex_mc dut (
    .clk(clk), .rstn(rstn), .clr(clr), .init_busy(init_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  bram_flex_mc #(.DEPTH(16), .OUTREG(1), .READ_FIRST("FALSE")) dut2 (
    .clk(clk), .rstn(rstn), .clr(1'b0), .init_busy(b_busy),
    .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata)
  );

  task automatic wait_init(output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    while (init_busy === 1'b1 && cnt < 6000) begin
      if (req_ready !== '0 || rsp_valid !== '0) bad++;
      cnt++;
      @(negedge clk); #1;
    end
  endtask

  // Single access on one channel; response expected exactly one cycle after the handshake edge.
  task automatic do_acc(input int ch, input bit wen, input int addr, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output bit got);
    int n;
    @(negedge clk);
    req_wen[ch] = wen;
    req_addr[ch*AW +: AW] = AW'(addr);
    req_wdata[ch*DW +: DW] = wd;
    req_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (req_ready[ch] !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    req_valid[ch] = 1'b0;
    #1;
    got = (rsp_valid === N'(1 << ch));
    rd = rsp_rdata[ch*DW +: DW];
  endtask

  task automatic test_reset();
    int cnt, bad;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (init_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", init_busy); else n_pass++;
    n_total++; if (req_ready !== 4'h0) $display("FAIL reset_ready got %h want 0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 4'h0) $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_rdata !== '0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else n_pass++;
    req_valid = '0;
    rstn = 1'b1;
    #1;
    wait_init(cnt, bad);
    n_total++; if (cnt != 5130) $display("FAIL init_busy_cycles got %0d want 5130", cnt); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL init_no_activity got %0d want 0", bad); else n_pass++;
  endtask

  task automatic test_init_values();
    int exp_v[7] = '{2, 4, 6, 7, 1, 3, 10};
    logic [DW-1:0] rd;
    bit got;
    for (int a = 0; a < 7; a++) begin
      do_acc(a % 4, 1'b0, a, '0, rd, got);
      n_total++; if (!got) $display("FAIL init_rsp addr %0d got none want 1", a); else n_pass++;
      n_total++; if (rd !== DW'(exp_v[a])) $display("FAIL init_word addr %0d got %0d want %0d", a, rd, exp_v[a]); else n_pass++;
    end
    do_acc(0, 1'b0, 5129, '0, rd, got);
    n_total++; if (!got || rd !== 20'd10) $display("FAIL init_last got %0d/%0d want 1/10", got, rd); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd;
    bit got;
    do_acc(0, 1'b1, 100, 20'hABCDE, rd, got);
    n_total++; if (!got) $display("FAIL wr_rsp got 0 want 1"); else n_pass++;
    n_total++; if (rd !== 20'd10) $display("FAIL wr_old_word got %h want a", rd); else n_pass++;
    do_acc(0, 1'b0, 100, '0, rd, got);
    n_total++; if (!got) $display("FAIL rd_rsp got 0 want 1"); else n_pass++;
    n_total++; if (rd !== 20'hABCDE) $display("FAIL rd_back got %h want abcde", rd); else n_pass++;
  endtask

  task automatic test_outreg_write_first();
    logic       t_wen [3] = '{1'b1, 1'b0, 1'b0};
    int         t_adr [3] = '{3, 3, 5};
    logic [DW-1:0] t_exp [3] = '{20'hABCDE, 20'hABCDE, 20'd3};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      b_wen[0] = t_wen[t];
      b_addr[BAW-1:0] = BAW'(t_adr[t]);
      b_wdata[DW-1:0] = 20'hABCDE;
      b_valid = 4'b0001;
      #1;
      n_total++; if (b_ready !== 4'b0001) $display("FAIL or_ready[%0d] got %h want 1", t, b_ready); else n_pass++;
      @(negedge clk);
      b_valid = '0;
      #1;
      n_total++; if (b_rsp_valid !== 4'h0) $display("FAIL or_early[%0d] got %h want 0", t, b_rsp_valid); else n_pass++;
      @(negedge clk); #1;
      n_total++; if (b_rsp_valid !== 4'b0001 || b_rsp_rdata[DW-1:0] !== t_exp[t])
        $display("FAIL or_rsp[%0d] got %h/%h want 1/%h", t, b_rsp_valid, b_rsp_rdata[DW-1:0], t_exp[t]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d [4] = '{20'd2, 20'd4, 20'd6, 20'd7};
    logic [DW-1:0] rd;
    bit got;
    int c;
    do_acc(3, 1'b0, 3, '0, rd, got);
    n_total++; if (!got || rd !== 20'd7) $display("FAIL rr_pre got %0d/%0d want 1/7", got, rd); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_wen[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(i);
    end
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_total++; if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_grant[%0d] got %h want %h", k, req_ready, 4'(1 << (k % 4))); else n_pass++;
      if (k > 0) begin
        c = (k - 1) % 4;
        n_total++; if (rsp_valid !== 4'(1 << c) || rsp_rdata[c*DW +: DW] !== exp_d[c])
          $display("FAIL rr_rsp[%0d] got %h/%0d want %h/%0d", k, rsp_valid, rsp_rdata[c*DW +: DW], 4'(1 << c), exp_d[c]);
        else n_pass++;
      end
      @(negedge clk); #1;
    end
    req_valid = '0;
    #1;
    n_total++; if (rsp_valid !== 4'b1000 || rsp_rdata[3*DW +: DW] !== 20'd7) $display("FAIL rr_last got %h/%0d want 8/7", rsp_valid, rsp_rdata[3*DW +: DW]); else n_pass++;
    n_total++; if (rsp_rdata[DW-1:0] !== 20'd2) $display("FAIL rr_hold got %0d want 2", rsp_rdata[DW-1:0]); else n_pass++;
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (req_ready !== 4'b0100) $display("FAIL solo_grant[%0d] got %h want 4", k, req_ready); else n_pass++;
      if (k > 0) begin
        n_total++; if (rsp_valid !== 4'b0100) $display("FAIL solo_rsp[%0d] got %h want 4", k, rsp_valid); else n_pass++;
      end
      @(negedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] rd;
    bit got;
    do_acc(1, 1'b0, 5130, '0, rd, got);
    n_total++; if (!got || rd !== '0) $display("FAIL oob_read got %0d/%0d want 1/0", got, rd); else n_pass++;
    do_acc(1, 1'b1, 5130, 20'd5, rd, got);
    n_total++; if (!got || rd !== '0) $display("FAIL oob_write got %0d/%0d want 1/0", got, rd); else n_pass++;
    do_acc(1, 1'b0, 0, '0, rd, got);
    n_total++; if (rd !== 20'd2) $display("FAIL oob_addr0 got %0d want 2", rd); else n_pass++;
    do_acc(1, 1'b0, 5129, '0, rd, got);
    n_total++; if (rd !== 20'd10) $display("FAIL oob_addr5129 got %0d want 10", rd); else n_pass++;
  endtask

  task automatic test_clr();
    int cnt, bad;
    logic [DW-1:0] rd;
    bit got;
    @(negedge clk);
    req_wen[1] = 1'b0;
    req_addr[AW +: AW] = AW'(7);
    req_wen[0] = 1'b0;
    req_addr[0 +: AW] = AW'(100);
    req_valid = 4'b0010;
    #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL clr_pre_grant got %h want 2", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0001;
    clr = 1'b1;
    #1;
    n_total++; if (rsp_valid !== 4'b0010 || rsp_rdata[DW +: DW] !== 20'd10) $display("FAIL clr_inflight got %h/%0d want 2/10", rsp_valid, rsp_rdata[DW +: DW]); else n_pass++;
    n_total++; if (req_ready !== 4'h0) $display("FAIL clr_edge_grant got %h want 0", req_ready); else n_pass++;
    @(negedge clk);
    clr = 1'b0;
    #1;
    wait_init(cnt, bad);
    req_valid = '0;
    n_total++; if (cnt != 5130) $display("FAIL clr_busy_cycles got %0d want 5130", cnt); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL clr_no_grant got %0d want 0", bad); else n_pass++;
    do_acc(0, 1'b0, 100, '0, rd, got);
    n_total++; if (!got || rd !== 20'd10) $display("FAIL clr_reinit got %0d/%h want 1/a", got, rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt, bad;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_wen[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(i);
    end
    req_valid = 4'b0111;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 4'b0001) $display("FAIL mid_third_rsp got %h want 1", rsp_valid); else n_pass++;
    rstn = 1'b0;
    req_valid = '0;
    #1;
    n_total++; if (rsp_valid !== 4'h0 || rsp_rdata !== '0) $display("FAIL mid_reset_rsp got %h/%h want 0/0", rsp_valid, rsp_rdata); else n_pass++;
    n_total++; if (init_busy !== 1'b1) $display("FAIL mid_reset_busy got %b want 1", init_busy); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (rsp_valid !== 4'h0) $display("FAIL mid_reset_hold got %h want 0", rsp_valid); else n_pass++;
    rstn = 1'b1;
    #1;
    wait_init(cnt, bad);
    n_total++; if (cnt != 5130) $display("FAIL mid_busy_cycles got %0d want 5130", cnt); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL mid_no_rsp_after got %0d want 0", bad); else n_pass++;
  endtask

  initial begin
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    b_valid = '0; b_wen = '0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_init_values();
    test_write_read();
    test_outreg_write_first();
    test_round_robin();
    test_out_of_range();
    test_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
